// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky-integrate-and-fire sweep controller.
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } lif_state_e;

    localparam int MAX_W     = 64;
    localparam int DEF_DEPTH = 256;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int ADDR_W = addr_w(DEF_DEPTH);

    localparam logic signed [MAX_W+1:0] SAT_ONE = {{(MAX_W+1){1'b0}}, 1'b1};

    // Adds two sign-extended operands and clamps to the signed range of a
    // w-bit word; the caller keeps the low w bits of the result.
    function automatic logic signed [MAX_W-1:0] sat_add(
        input logic signed [MAX_W+1:0] a,
        input logic signed [MAX_W+1:0] b,
        input int                      w
    );
        logic signed [MAX_W+1:0] sum;
        logic signed [MAX_W+1:0] hi;
        logic signed [MAX_W+1:0] lo;
        sum = a + b;
        hi  = (SAT_ONE <<< (w - 1)) - SAT_ONE;
        lo  = -hi - SAT_ONE;
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational per-neuron update: leak, add synaptic current, saturate,
// threshold, and select the reset potential on a spike.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int THRESHOLD  = 1000,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 4
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] cur,
    output logic signed [WIDTH-1:0] v_next,
    output logic                    spike
);

    localparam int EXT = MAX_W + 2 - WIDTH;
    localparam logic signed [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);
    localparam logic signed [WIDTH-1:0] VRST = WIDTH'(V_RESET);

    logic signed [WIDTH-1:0] leak;
    logic signed [WIDTH-1:0] v_sat;
    logic signed [MAX_W+1:0] kept;
    logic signed [MAX_W+1:0] cur_ext;

    // Operands are widened well past WIDTH+2 so the leak subtraction and the
    // current add can never wrap before the clamp.
    always_comb begin
        leak    = v >>> LEAK_SHIFT;
        kept    = {{EXT{v[WIDTH-1]}}, v} - {{EXT{leak[WIDTH-1]}}, leak};
        cur_ext = {{EXT{cur[WIDTH-1]}}, cur};
        v_sat   = WIDTH'(sat_add(kept, cur_ext, WIDTH));
        spike   = (v_sat >= THR);
        v_next  = spike ? VRST : v_sat;
    end

endmodule

// File: rtl/lif_sweep_ctrl.sv
// Owns the neuron-state SRAM port and runs one read/update/write pass over
// neurons 0..N_NEURONS-1 per accepted start.
module lif_sweep_ctrl
    import lif_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  DEPTH      = DEF_DEPTH,
    parameter int  N_NEURONS  = DEF_DEPTH,
    parameter int  THRESHOLD  = 1000,
    parameter int  V_RESET    = 0,
    parameter int  LEAK_SHIFT = 4,
    localparam int AW         = addr_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    sram_we,
    output logic [AW-1:0]           sram_addr,
    output logic signed [WIDTH-1:0] sram_wdata,
    input  logic signed [WIDTH-1:0] sram_rdata,
    output logic [AW-1:0]           cur_idx,
    input  logic signed [WIDTH-1:0] cur_in,
    output logic                    spike_valid,
    output logic [AW-1:0]           spike_id
);

    localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

    lif_state_e              state;
    logic [AW-1:0]           idx;
    logic signed [WIDTH-1:0] upd_v;
    logic                    upd_spike;

    lif_update #(
        .WIDTH     (WIDTH),
        .THRESHOLD (THRESHOLD),
        .V_RESET   (V_RESET),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_update (
        .v     (sram_rdata),
        .cur   (cur_in),
        .v_next(upd_v),
        .spike (upd_spike)
    );

    // Every output is a register updated on the transition into the state
    // that owns it, so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            cur_idx     <= '0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
        end else begin
            done        <= 1'b0;
            sram_we     <= 1'b0;
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        idx       <= '0;
                        busy      <= 1'b1;
                        sram_addr <= '0;
                        cur_idx   <= '0;
                    end
                end
                READ: begin
                    state <= CALC;
                end
                CALC: begin
                    // sram_wdata doubles as the registered v_next.
                    state       <= WRITE;
                    sram_we     <= 1'b1;
                    sram_wdata  <= upd_v;
                    spike_valid <= upd_spike;
                    spike_id    <= idx;
                end
                WRITE: begin
                    if (idx == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= READ;
                        idx       <= idx + AW'(1);
                        sram_addr <= idx + AW'(1);
                        cur_idx   <= idx + AW'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    idx       <= '0;
                    sram_addr <= '0;
                    cur_idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
